axis_rr_distributor: RTL

Frame-level round-robin distributor: accepts one AXI stream and steers each complete frame to one of M_COUNT output streams, rotating fairly among the outputs that are currently enabled. It is the fan-out counterpart to the request/grant arbitration used at stream mux inputs. It feeds parallel processing lanes or per-lane FIFOs from a single source. Selection is made once per frame and never changes mid-frame. Output is fully registered with a skid stage, so it breaks all combinational paths in both directions.

---
 rtl/axis_rr_distributor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/axis_rr_distributor.sv
// axis_rr_distributor: steers whole AXI-Stream frames round-robin across the enabled outputs,
// with a registered output stage plus one skid register.
module axis_rr_distributor #(
  parameter int unsigned M_COUNT     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  input  logic [M_COUNT-1:0]               m_axis_tready,
  output logic [M_COUNT-1:0]               m_axis_tlast,
  output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
  input  logic [M_COUNT-1:0]               m_enable,
  output logic                             sel_valid,
  output logic [$clog2(M_COUNT)-1:0]       sel_encoded
);

  localparam int unsigned SEL_WIDTH = $clog2(M_COUNT);

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  state_t                state;
  logic [SEL_WIDTH-1:0]  last_sel;
  logic [SEL_WIDTH-1:0]  sel_pick;
  logic                  sel_any;
  logic                  frame_next;
  logic                  ready_next;

  logic                  in_beat;
  logic [M_COUNT-1:0]    in_tag;
  logic                  out_valid;
  logic                  out_drain;
  logic                  out_load;
  logic                  temp_valid;
  logic                  load_temp;
  logic                  temp_valid_next;

  logic [M_COUNT-1:0]    out_tag;
  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;
  logic [USER_WIDTH-1:0] out_user;

  logic [M_COUNT-1:0]    temp_tag;
  logic [DATA_WIDTH-1:0] temp_data;
  logic [KEEP_WIDTH-1:0] temp_keep;
  logic                  temp_last;
  logic [USER_WIDTH-1:0] temp_user;

  assign sel_any    = |m_enable;
  assign in_beat    = s_axis_tvalid && s_axis_tready;
  assign in_tag     = M_COUNT'(1) << sel_encoded;
  assign out_valid  = |out_tag;
  assign temp_valid = |temp_tag;
  // Ready bits of ports other than the tagged one are masked off here.
  assign out_drain  = |(out_tag & m_axis_tready);
  assign out_load   = !out_valid || out_drain;
  assign load_temp  = in_beat && (temp_valid || (out_valid && !out_drain));
  assign temp_valid_next = load_temp || (temp_valid && !out_load);

  // First enabled port searching upward from last+1, wrapping; lowest offset wins.
  always_comb begin
    sel_pick = last_sel;
    for (int i = M_COUNT; i > 0; i--) begin
      if (m_enable[SEL_WIDTH'((32'(last_sel) + 32'(i)) % M_COUNT)])
        sel_pick = SEL_WIDTH'((32'(last_sel) + 32'(i)) % M_COUNT);
    end
  end

  // Frame-state lookahead and the registered input ready it gates.
  always_comb begin
    frame_next = (state == FRAME);
    if (state == IDLE)
      frame_next = s_axis_tvalid && sel_any;
    else if (in_beat && s_axis_tlast)
      frame_next = 1'b0;
    ready_next = frame_next && !temp_valid_next &&
                 (!out_valid || out_drain || !in_beat);
  end

  // Frame FSM: port selection happens only on the IDLE->FRAME edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel_valid     <= 1'b0;
      sel_encoded   <= '0;
      last_sel      <= SEL_WIDTH'(M_COUNT - 1);
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= ready_next;
      sel_valid     <= frame_next;
      case (state)
        IDLE: begin
          if (frame_next) begin
            state       <= FRAME;
            sel_encoded <= sel_pick;
            last_sel    <= sel_pick;
          end
        end
        FRAME: begin
          if (!frame_next) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register plus skid register; skid always refills the output first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tag   <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_user  <= '0;
      temp_tag  <= '0;
      temp_data <= '0;
      temp_keep <= '0;
      temp_last <= 1'b0;
      temp_user <= '0;
    end else begin
      if (out_load) begin
        if (temp_valid) begin
          out_tag  <= temp_tag;
          out_data <= temp_data;
          out_keep <= temp_keep;
          out_last <= temp_last;
          out_user <= temp_user;
        end else if (in_beat) begin
          out_tag  <= in_tag;
          out_data <= s_axis_tdata;
          out_keep <= s_axis_tkeep;
          out_last <= s_axis_tlast;
          out_user <= s_axis_tuser;
        end else begin
          out_tag  <= '0;
        end
      end
      if (load_temp) begin
        temp_tag  <= in_tag;
        temp_data <= s_axis_tdata;
        temp_keep <= s_axis_tkeep;
        temp_last <= s_axis_tlast;
        temp_user <= s_axis_tuser;
      end else if (out_load) begin
        temp_tag  <= '0;
      end
    end
  end

  assign m_axis_tvalid = out_tag;
  assign m_axis_tdata  = {M_COUNT{out_data}};
  assign m_axis_tkeep  = KEEP_ENABLE ? {M_COUNT{out_keep}} : '1;
  assign m_axis_tlast  = {M_COUNT{out_last}};
  assign m_axis_tuser  = {M_COUNT{out_user}};

endmodule
